// File: rtl/axi_rdma_burst.sv
// AXI4 read DMA: splits a beat count into 4 KB-safe INCR bursts and streams the data out on AXI4-Stream.
// Latency: AR valid 1 cycle after start; R beat visible on the stream 1 cycle after its handshake; done 1 cycle after last beat.
// Backpressure: tready only stalls the drain; R is never stalled because AR issue is gated by buffer credits.
module axi_rdma_burst #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [LEN_WIDTH-1:0]  num_beats,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SZ    = $clog2(BYTES);
  // Pointer width is at least 1 so a depth-1 buffer still has a legal index; capacity is enforced by credits.
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = PW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_req_left;
  logic [LEN_WIDTH-1:0]  r_total;
  logic [LEN_WIDTH-1:0]  r_out_cnt;
  logic [CW-1:0]         r_reserved;
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic                  r_error;
  logic [DATA_WIDTH-1:0] r_mem [2**PW];

  logic [12:0] w_to_4k;
  logic [31:0] w_len;
  logic [31:0] w_credits;
  logic        w_arvalid;
  logic        w_ar_hs;
  logic        w_push;
  logic        w_pop;
  logic        w_tvalid;
  logic        w_last;
  logic        w_busy;
  logic        w_unused;

  // rlast and rresp[0] carry no information this engine acts on; beats are counted instead.
  assign w_unused = ^{m_axi_rlast, m_axi_rresp[0]};

  // Burst length: smallest of the burst cap, what is left to request and the room before the next 4 KB page.
  always_comb begin
    w_to_4k = (13'd4096 - {1'b0, r_addr[11:0]}) >> SZ;
    w_len   = 32'(MAX_BURST);
    if (32'(r_req_left) < w_len) w_len = 32'(r_req_left);
    if (32'(w_to_4k) < w_len)    w_len = 32'(w_to_4k);
  end

  // Credits count buffer slots not yet filled or promised to an outstanding burst.
  assign w_credits = 32'(FIFO_DEPTH) - 32'(r_count) - 32'(r_reserved);
  // AR only depends on registered state, so it cannot be withdrawn before arready: credits only grow while waiting.
  assign w_arvalid = (r_state == S_RUN) && (r_req_left != '0) && (w_credits >= w_len);
  assign w_ar_hs   = w_arvalid && m_axi_arready;
  assign w_busy    = (r_state != S_IDLE);
  assign w_push    = m_axi_rvalid && w_busy;
  assign w_tvalid  = (r_count != '0);
  assign w_pop     = w_tvalid && m_axis_tready;
  assign w_last    = w_tvalid && (r_out_cnt == r_total - LEN_WIDTH'(1));

  assign busy          = w_busy;
  assign done          = (r_state == S_DONE);
  assign error         = r_error;
  assign m_axi_arvalid = w_arvalid;
  assign m_axi_araddr  = w_arvalid ? r_addr : '0;
  assign m_axi_arlen   = w_arvalid ? 8'(w_len - 32'd1) : 8'd0;
  assign m_axi_arsize  = 3'(SZ);
  assign m_axi_arburst = 2'b01;
  assign m_axi_rready  = w_busy;
  assign m_axis_tvalid = w_tvalid;
  assign m_axis_tdata  = w_tvalid ? r_mem[r_rptr] : '0;
  assign m_axis_tlast  = w_last;

  // Control FSM, request address/count bookkeeping, output beat counter and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_req_left <= '0;
      r_total    <= '0;
      r_out_cnt  <= '0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr     <= {src_addr[ADDR_WIDTH-1:SZ], {SZ{1'b0}}};
            r_req_left <= num_beats;
            r_total    <= num_beats;
            r_out_cnt  <= '0;
            r_error    <= 1'b0;
            r_state    <= (num_beats == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_ar_hs) begin
            r_addr     <= r_addr + ADDR_WIDTH'(w_len << SZ);
            r_req_left <= r_req_left - LEN_WIDTH'(w_len);
          end
          if (w_pop) r_out_cnt <= r_out_cnt + LEN_WIDTH'(1);
          if (w_pop && w_last) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_push && m_axi_rresp[1]) r_error <= 1'b1;
    end
  end

  // Credit accounting: a burst reserves its beats at AR, each R beat moves one from reserved to occupied.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_reserved <= '0;
      r_count    <= '0;
    end else begin
      r_reserved <= r_reserved + (w_ar_hs ? CW'(w_len) : CW'(0)) - CW'(w_push);
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Buffer pointers; a simultaneous push and pop advances both and leaves the occupancy unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

  // Buffer storage; stale contents are never visible because tdata is masked when empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= m_axi_rdata;
  end

endmodule

// File: tb/tb_axi_rdma_burst.sv
// Bench for axi_rdma_burst: AXI4 read slave with memory model, stream sink and beat scoreboard.
// Inputs are driven on the falling edge; the control thread acts 2 time units after the rising edge.
// Expected beats and bursts are queued at stimulus time and popped on each observed handshake.
module tb_axi_rdma_burst;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LW = 16;
  localparam int MB = 16;
  localparam int FD = 32;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;
  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start;
  logic [AW-1:0] src_addr;
  logic [LW-1:0] num_beats;
  logic          busy, done, error;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arvalid;
  logic          m_axi_arready = 1'b0;
  logic [DW-1:0] m_axi_rdata   = '0;
  logic [1:0]    m_axi_rresp   = 2'b00;
  logic          m_axi_rlast   = 1'b0;
  logic          m_axi_rvalid  = 1'b0;
  logic          m_axi_rready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;

  axi_rdma_burst #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_BURST(MB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .num_beats(num_beats),
    .busy(busy), .done(done), .error(error),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  // Scoreboard and bench state shared by the control thread and the bus models.
  beat_t exp_q[$];
  ar_t   exp_ar[$];
  ar_t   sl_q[$];
  int    cyc = 0;
  int    r_cnt = 0, t_cnt = 0, req_cnt = 0, done_cnt = 0, ar_seen = 0;
  int    first_r_cyc = -1, err_cyc = -1, last_hs_cyc = -1;
  int    err_beat = -1, t_mode = 1, beat = 0;
  bit    ar_rand = 0, first_tv = 0, zero_xfer = 0;
  bit    r_hold = 0, ar_wait = 0, tv_hold = 0, prev_done = 0;
  ar_t   cur, e, ar_prev;
  beat_t b;
  logic [31:0] tv_prev_data;
  logic        tv_prev_last;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave, sink and monitor: choose inputs for the coming edge and score the handshakes that edge will complete.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete(); exp_ar.delete(); sl_q.delete();
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
      m_axi_rresp = 2'b00; m_axi_rdata = '0; m_axis_tready = 1'b0;
      r_hold = 0; ar_wait = 0; tv_hold = 0; prev_done = 0; beat = 0;
    end else begin
      // R channel: in-order beats from accepted bursts, held until taken.
      if (!r_hold) begin
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
        if (sl_q.size() != 0 && $urandom_range(0, 3) != 0) begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = mem_word(sl_q[0].addr + 32'(beat * 4));
          m_axi_rlast  = (beat == int'(sl_q[0].len));
          m_axi_rresp  = (r_cnt == err_beat) ? 2'b10 : 2'b00;
        end
      end
      if (m_axi_rvalid && m_axi_rready) begin
        chk("fifo_room", (r_cnt - t_cnt) < FD, 1'b1);
        if (first_r_cyc < 0) first_r_cyc = cyc;
        if (m_axi_rresp[1]) err_cyc = cyc;
        r_cnt++;
        r_hold = 0;
        if (beat == int'(sl_q[0].len)) begin
          void'(sl_q.pop_front());
          beat = 0;
        end else beat++;
      end else r_hold = m_axi_rvalid;

      // AR channel.
      if (ar_wait) chk("ar_hold", {m_axi_arvalid, m_axi_araddr, m_axi_arlen}, {1'b1, ar_prev.addr, ar_prev.len});
      if (m_axi_arvalid) ar_seen++;
      m_axi_arready = ar_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (m_axi_arvalid && m_axi_arready) begin
        cur.addr = m_axi_araddr;
        cur.len  = m_axi_arlen;
        if (exp_ar.size() == 0) chk("ar_extra", 1, 0);
        else begin
          e = exp_ar.pop_front();
          chk("araddr", cur.addr, e.addr);
          chk("arlen", cur.len, e.len);
        end
        chk("ar_4k", (int'(cur.addr[11:0]) + (int'(cur.len) + 1) * 4) <= 4096, 1'b1);
        req_cnt += int'(cur.len) + 1;
        chk("reserve", (req_cnt - t_cnt) <= FD, 1'b1);
        sl_q.push_back(cur);
        ar_wait = 0;
      end else begin
        ar_wait = m_axi_arvalid;
        ar_prev.addr = m_axi_araddr;
        ar_prev.len  = m_axi_arlen;
      end

      // Stream sink.
      if (tv_hold) chk("t_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, tv_prev_last, tv_prev_data});
      case (t_mode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        default: m_axis_tready = ($urandom_range(0, 1) != 0);
      endcase
      if (m_axis_tvalid) begin
        if (first_tv) begin
          chk("first_word", cyc, first_r_cyc + 1);
          first_tv = 0;
        end
        if (m_axis_tready) begin
          if (exp_q.size() == 0) chk("t_extra", 1, 0);
          else begin
            b = exp_q.pop_front();
            chk("tdata", m_axis_tdata, b.data);
            chk("tlast", m_axis_tlast, b.last);
          end
          if (m_axis_tlast) last_hs_cyc = cyc;
          t_cnt++;
          tv_hold = 0;
        end else begin
          tv_hold = 1;
          tv_prev_data = m_axis_tdata;
          tv_prev_last = m_axis_tlast;
        end
      end else tv_hold = 0;

      // Completion and error timing.
      if (prev_done) chk("busy_fall", busy, 0);
      if (err_cyc >= 0 && cyc == err_cyc)     chk("err_before", error, 0);
      if (err_cyc >= 0 && cyc == err_cyc + 1) chk("err_set", error, 1);
      if (done) begin
        done_cnt++;
        if (!zero_xfer) chk("done_lat", cyc, last_hs_cyc + 1);
      end
      prev_done = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_arvalid"}, m_axi_arvalid, 0);
    chk({tag, "_rready"}, m_axi_rready, 0);
    chk({tag, "_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_tlast"}, m_axis_tlast, 0);
    chk({tag, "_araddr"}, m_axi_araddr, 0);
    chk({tag, "_arlen"}, m_axi_arlen, 0);
    chk({tag, "_tdata"}, m_axis_tdata, 0);
  endtask

  task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
    ar_t t;
    t.addr = a;
    t.len  = l;
    exp_ar.push_back(t);
  endtask

  task automatic launch(input logic [31:0] addr, input int n);
    beat_t t;
    for (int i = 0; i < n; i++) begin
      t.data = mem_word(addr + 32'(i * 4));
      t.last = (i == n - 1);
      exp_q.push_back(t);
    end
    first_r_cyc = -1; err_cyc = -1; first_tv = 1; zero_xfer = (n == 0);
    done_cnt = 0; r_cnt = 0; t_cnt = 0; req_cnt = 0; ar_seen = 0;
    src_addr = addr; num_beats = LW'(n); start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_on", busy, 1);
    chk("arvalid_on", m_axi_arvalid, n > 0);
    chk("err_clr", error, 0);
  endtask

  task automatic wait_done(input string tag, input int n);
    int k = 0;
    while (done_cnt == 0 && k < 5000) begin
      tick();
      k++;
    end
    chk({tag, "_done_seen"}, done_cnt != 0, 1);
    repeat (3) tick();
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_beats"}, t_cnt, n);
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_ar_left"}, exp_ar.size(), 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; src_addr = '0; num_beats = '0;
    repeat (3) tick();
    check_idle_outputs("rst");
    chk("arsize", m_axi_arsize, 3'd2);
    chk("arburst", m_axi_arburst, 2'b01);
    reset = 1'b0;
    tick();

    // 40 beats at 0x1000 with an ignored start mid-transfer.
    ar_rand = 0; t_mode = 1;
    push_ar(32'h1000, 8'd15); push_ar(32'h1040, 8'd15); push_ar(32'h1080, 8'd7);
    launch(32'h1000, 40);
    repeat (10) tick();
    src_addr = 32'h8000; num_beats = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t1", 40);
    chk("t1_err", error, 0);

    // 4 KB boundary split with random ready on both sides.
    ar_rand = 1; t_mode = 2;
    push_ar(32'h0FF0, 8'd3); push_ar(32'h1000, 8'd3);
    launch(32'h0FF0, 8);
    wait_done("t2", 8);

    // Long stall on the stream side: reservation stops at the buffer depth.
    ar_rand = 0; t_mode = 0;
    for (int i = 0; i < 6; i++) push_ar(32'h2000 + 32'(i * 64), 8'd15);
    push_ar(32'h2180, 8'd3);
    launch(32'h2000, 100);
    repeat (200) tick();
    chk("stall_req", req_cnt, FD);
    chk("stall_r", r_cnt, FD);
    chk("stall_t", t_cnt, 0);
    t_mode = 2;
    wait_done("t3", 100);

    // Error response on beat 5 of 20.
    t_mode = 1; err_beat = 5;
    push_ar(32'h3000, 8'd15); push_ar(32'h3040, 8'd3);
    launch(32'h3000, 20);
    wait_done("t4", 20);
    chk("t4_err_sticky", error, 1);
    err_beat = -1;

    // Zero-length transfer; a start during DONE is ignored.
    launch(32'h4000, 0);
    chk("zero_done", done, 1);
    src_addr = 32'h7000; num_beats = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_idle_busy", busy, 0);
    chk("zero_idle_done", done, 0);
    repeat (5) tick();
    chk("zero_ignored", busy, 0);
    chk("zero_no_ar", ar_seen, 0);
    chk("zero_done_once", done_cnt, 1);

    // Reset in the middle of a transfer, then a clean 10-beat transfer.
    push_ar(32'h5000, 8'd15); push_ar(32'h5040, 8'd15); push_ar(32'h5080, 8'd15); push_ar(32'h50C0, 8'd11);
    launch(32'h5000, 60);
    repeat (12) tick();
    reset = 1'b1;
    tick();
    check_idle_outputs("mid_rst");
    reset = 1'b0;
    tick();
    push_ar(32'h6000, 8'd9);
    launch(32'h6000, 10);
    wait_done("t6", 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

endmodule
